// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_pkg
// Description : Shared widths and the writeback request record used by the
//               register-file writeback arbiter and its request FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

    localparam int c_NREG = 32;
    localparam int c_AW   = 5;
    localparam int c_DW   = 128;

    // One queued register-file write.
    typedef struct packed {
        logic [c_AW-1:0] addr;
        logic [c_DW-1:0] data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : DEPTH-entry in-order queue of writeback requests. Exposes
//               every slot plus a per-slot valid mask so the top can build
//               the pending-register vector.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  wb_req_t          push_data,
    output logic             push_ready,
    input  logic             pop,
    output wb_req_t          head,
    output logic             empty,
    output wb_req_t          entries [DEPTH],
    output logic [DEPTH-1:0] entry_valid
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH) + 1;

    wb_req_t         r_mem [DEPTH];
    logic [c_PW-1:0] r_rd;
    logic [c_PW-1:0] r_wr;
    logic [c_CW-1:0] r_count;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    int              w_off;

    // Pointer advance with explicit wrap so non-power-of-two depths stay safe.
    function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
        return (p == c_PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO never accepts, even if the head leaves on the same edge.
    assign w_full      = (r_count == c_CW'(DEPTH));
    assign empty       = (r_count == '0);
    assign push_ready  = !w_full;
    assign w_push      = push_valid && !w_full;
    assign w_pop       = pop && !empty;
    assign head        = r_mem[r_rd];
    assign entries     = r_mem;

    // Pointer and occupancy update; reset drops everything queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= f_inc(r_wr);
            if (w_pop)  r_rd <= f_inc(r_rd);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; slot contents are only meaningful under entry_valid.
    always_ff @(posedge clk) begin
        if (w_push && !reset) r_mem[r_wr] <= push_data;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        entry_valid = '0;
        w_off       = 0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off          = (i - int'(r_rd) + DEPTH) % DEPTH;
            entry_valid[i] = (w_off < int'(r_count));
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Two-requester (ALU, load unit) round-robin arbiter driving a
//               single register-file write port, one write per cycle, with
//               a per-register pending vector for hazard tracking.
//               AW/DW must match the package widths of wb_req_t.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREG  = c_NREG,
    parameter int AW    = c_AW,
    parameter int DW    = c_DW,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_addr,
    input  logic [DW-1:0]   req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_addr,
    input  logic [DW-1:0]   req1_data,
    output logic            req1_ready,
    output logic            we3,
    output logic [AW-1:0]   a3,
    output logic [DW-1:0]   wd3,
    output logic [NREG-1:0] pending,
    output logic            idle
);

    wb_req_t          w_push0;
    wb_req_t          w_push1;
    wb_req_t          w_head0;
    wb_req_t          w_head1;
    wb_req_t          w_sel;
    wb_req_t          w_ent0 [DEPTH];
    wb_req_t          w_ent1 [DEPTH];
    logic [DEPTH-1:0] w_vld0;
    logic [DEPTH-1:0] w_vld1;
    logic             w_empty0;
    logic             w_empty1;
    logic             w_any;
    logic             w_gnt1;
    logic             w_pop0;
    logic             w_pop1;
    logic             r_last1;   // requester 1 received the most recent grant

    assign w_push0 = '{addr: c_AW'(req0_addr), data: c_DW'(req0_data)};
    assign w_push1 = '{addr: c_AW'(req1_addr), data: c_DW'(req1_data)};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk         (clk),
        .reset       (reset),
        .push_valid  (req0_valid),
        .push_data   (w_push0),
        .push_ready  (req0_ready),
        .pop         (w_pop0),
        .head        (w_head0),
        .empty       (w_empty0),
        .entries     (w_ent0),
        .entry_valid (w_vld0)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk         (clk),
        .reset       (reset),
        .push_valid  (req1_valid),
        .push_data   (w_push1),
        .push_ready  (req1_ready),
        .pop         (w_pop1),
        .head        (w_head1),
        .empty       (w_empty1),
        .entries     (w_ent1),
        .entry_valid (w_vld1)
    );

    // Round-robin: on contention the requester not granted last wins;
    // a lone non-empty FIFO always wins.
    assign w_any  = !w_empty0 || !w_empty1;
    assign w_gnt1 = !w_empty1 && (w_empty0 || !r_last1);
    assign w_pop1 = w_gnt1;
    assign w_pop0 = !w_empty0 && !w_gnt1;
    assign w_sel  = w_gnt1 ? w_head1 : w_head0;

    // Write-port registers: load the granted head, or drop we3 and hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            we3     <= 1'b0;
            a3      <= '0;
            wd3     <= '0;
            r_last1 <= 1'b1;
        end else if (w_any) begin
            we3     <= 1'b1;
            a3      <= AW'(w_sel.addr);
            wd3     <= DW'(w_sel.data);
            r_last1 <= w_gnt1;
        end else begin
            we3     <= 1'b0;
        end
    end

    // Pending: every live FIFO slot plus the write currently on the port.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_vld0[i] && (int'(w_ent0[i].addr) < NREG)) pending[w_ent0[i].addr] = 1'b1;
            if (w_vld1[i] && (int'(w_ent1[i].addr) < NREG)) pending[w_ent1[i].addr] = 1'b1;
        end
        if (we3 && (int'(a3) < NREG)) pending[a3] = 1'b1;
    end

    assign idle = w_empty0 && w_empty1 && !we3;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench: directed vector table, multi-cycle
//               corner sequences and randomized traffic against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int c_DEPTH = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid;
    logic [4:0]   req0_addr;
    logic [127:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [4:0]   req1_addr;
    logic [127:0] req1_data;
    logic         req1_ready;
    logic         we3;
    logic [4:0]   a3;
    logic [127:0] wd3;
    logic [31:0]  pending;
    logic         idle;

    always #5 clk = ~clk;

    regfile_wb_arbiter u_dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .we3        (we3),
        .a3         (a3),
        .wd3        (wd3),
        .pending    (pending),
        .idle       (idle)
    );

    // Reference model: one queue per requester and the architected outputs.
    typedef struct { logic [4:0] a; logic [127:0] d; } ent_t;
    ent_t         q0[$];
    ent_t         q1[$];
    logic         m_we3;
    logic [4:0]   m_a3;
    logic [127:0] m_wd3;
    bit           m_last1;
    bit           acc0;
    bit           acc1;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int wlog[$];
    int clog[$];

    localparam logic [127:0] c_D5 = 128'h0ABCDE12_30ABCDE1_230ABCDE_12300000;
    localparam logic [127:0] c_D1 = {4{32'h11111111}};
    localparam logic [127:0] c_D2 = {4{32'h22222222}};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_pend();
        logic [31:0] p;
        p = '0;
        foreach (q0[i]) p[q0[i].a] = 1'b1;
        foreach (q1[i]) p[q1[i].a] = 1'b1;
        if (m_we3) p[m_a3] = 1'b1;
        return p;
    endfunction

    task automatic drive(input bit r, input bit v0, input logic [4:0] a0, input logic [127:0] d0,
                         input bit v1, input logic [4:0] a1, input logic [127:0] d1);
        reset = r; req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    // One clock: advance the model at the edge, then compare 1 ns later.
    task automatic step();
        ent_t h;
        @(posedge clk);
        cyc++;
        if (reset) begin
            q0.delete(); q1.delete();
            m_we3 = 1'b0; m_a3 = '0; m_wd3 = '0; m_last1 = 1'b1;
            acc0 = 1'b0; acc1 = 1'b0;
        end else begin
            acc0 = req0_valid && (q0.size() < c_DEPTH);
            acc1 = req1_valid && (q1.size() < c_DEPTH);
            if (q0.size() > 0 && (q1.size() == 0 || m_last1)) begin
                h = q0.pop_front(); m_we3 = 1'b1; m_a3 = h.a; m_wd3 = h.d; m_last1 = 1'b0;
            end else if (q1.size() > 0) begin
                h = q1.pop_front(); m_we3 = 1'b1; m_a3 = h.a; m_wd3 = h.d; m_last1 = 1'b1;
            end else begin
                m_we3 = 1'b0;
            end
            if (acc0) q0.push_back('{req0_addr, req0_data});
            if (acc1) q1.push_back('{req1_addr, req1_data});
        end
        #1;
        chk("m_we3", we3, m_we3);
        chk("m_a3", a3, m_a3);
        chk("m_wd3", wd3, m_wd3);
        chk("m_pending", pending, exp_pend());
        chk("m_idle", idle, (q0.size() == 0) && (q1.size() == 0) && !m_we3);
        chk("m_ready0", req0_ready, q0.size() < c_DEPTH);
        chk("m_ready1", req1_ready, q1.size() < c_DEPTH);
        if (we3 === 1'b1) begin
            wlog.push_back(int'(a3));
            clog.push_back(cyc);
        end
    endtask

    typedef struct {
        bit rst; bit v0; logic [4:0] a0; logic [127:0] d0;
        bit v1; logic [4:0] a1; logic [127:0] d1;
        bit we3; logic [4:0] a3; logic [127:0] wd3; logic [31:0] pend;
        bit idle; bit r0; bit r1;
    } vec_t;

    function automatic vec_t mk(bit rst, bit v0, logic [4:0] a0, logic [127:0] d0,
                                bit v1, logic [4:0] a1, logic [127:0] d1,
                                bit we, logic [4:0] a, logic [127:0] wd, logic [31:0] pd,
                                bit id, bit r0, bit r1);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.we3 = we; v.a3 = a; v.wd3 = wd; v.pend = pd; v.idle = id; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    vec_t tbl [12];

    initial begin
        int i0;
        int i1;
        bit saw0;
        bit saw1;
        int sat_a[6];
        int r1_a[4];
        sat_a = '{1, 7, 2, 8, 3, 9};
        r1_a  = '{10, 11, 12, 13};

        drive(1, 0, 0, 0, 0, 0, 0);

        // Reset/idle, single write latency, same-address contention.
        tbl[0]  = mk(1, 0, 0, 0,    0, 0, 0,     0, 0,  0,    32'h0,    1, 1, 1);
        tbl[1]  = mk(0, 0, 0, 0,    0, 0, 0,     0, 0,  0,    32'h0,    1, 1, 1);
        tbl[2]  = mk(0, 0, 0, 0,    0, 0, 0,     0, 0,  0,    32'h0,    1, 1, 1);
        tbl[3]  = mk(0, 0, 0, 0,    0, 0, 0,     0, 0,  0,    32'h0,    1, 1, 1);
        tbl[4]  = mk(0, 1, 5, c_D5, 0, 0, 0,     0, 0,  0,    32'h20,   0, 1, 1);
        tbl[5]  = mk(0, 0, 0, 0,    0, 0, 0,     1, 5,  c_D5, 32'h20,   0, 1, 1);
        tbl[6]  = mk(0, 0, 0, 0,    0, 0, 0,     0, 5,  c_D5, 32'h0,    1, 1, 1);
        tbl[7]  = mk(1, 0, 0, 0,    0, 0, 0,     0, 0,  0,    32'h0,    1, 1, 1);
        tbl[8]  = mk(0, 1, 14, c_D1, 1, 14, c_D2, 0, 0, 0,    32'h4000, 0, 1, 1);
        tbl[9]  = mk(0, 0, 0, 0,    0, 0, 0,     1, 14, c_D1, 32'h4000, 0, 1, 1);
        tbl[10] = mk(0, 0, 0, 0,    0, 0, 0,     1, 14, c_D2, 32'h4000, 0, 1, 1);
        tbl[11] = mk(0, 0, 0, 0,    0, 0, 0,     0, 14, c_D2, 32'h0,    1, 1, 1);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
            step();
            chk($sformatf("tbl%0d_we3", i), we3, tbl[i].we3);
            chk($sformatf("tbl%0d_a3", i), a3, tbl[i].a3);
            chk($sformatf("tbl%0d_wd3", i), wd3, tbl[i].wd3);
            chk($sformatf("tbl%0d_pending", i), pending, tbl[i].pend);
            chk($sformatf("tbl%0d_idle", i), idle, tbl[i].idle);
            chk($sformatf("tbl%0d_ready0", i), req0_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_ready1", i), req1_ready, tbl[i].r1);
        end

        // Both requesters saturated: strict alternation, no bubbles.
        drive(1, 0, 0, 0, 0, 0, 0); step();
        wlog.delete(); clog.delete();
        i0 = 0; i1 = 0; saw0 = 0; saw1 = 0;
        for (int c = 0; c < 12; c++) begin
            drive(0, i0 < 3, 5'(sat_a[(i0 < 3) ? 2 * i0 : 4]), {16{3'b000, 5'(sat_a[(i0 < 3) ? 2 * i0 : 4])}},
                     i1 < 3, 5'(sat_a[(i1 < 3) ? 2 * i1 + 1 : 5]), {16{3'b000, 5'(sat_a[(i1 < 3) ? 2 * i1 + 1 : 5])}});
            step();
            if (acc0) i0++;
            if (acc1) i1++;
            if (req0_ready === 1'b0) saw0 = 1;
            if (req1_ready === 1'b0) saw1 = 1;
        end
        chk("sat_count", wlog.size(), 6);
        for (int k = 0; k < 6; k++)
            chk($sformatf("sat_a3_%0d", k), (k < wlog.size()) ? wlog[k] : -1, sat_a[k]);
        for (int k = 1; k < 6; k++)
            chk($sformatf("sat_gap_%0d", k), (k < clog.size()) ? clog[k] - clog[k-1] : -1, 1);
        chk("sat_ready0_dropped", saw0, 1);
        chk("sat_ready1_dropped", saw1, 1);

        // Fill both FIFOs, reset mid-flight with a request on the reset edge.
        drive(1, 0, 0, 0, 0, 0, 0); step();
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 5'(20 + c), {4{32'hA0A0_0000 + c}}, 1, 5'(24 + c), {4{32'hB0B0_0000 + c}});
            step();
        end
        drive(1, 1, 30, c_D1, 1, 31, c_D2); step();
        chk("rst_we3", we3, 0);
        chk("rst_pending", pending, 0);
        chk("rst_idle", idle, 1);
        wlog.delete(); clog.delete();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) step();
        chk("rst_no_stale_writes", wlog.size(), 0);

        // Requester 1 alone, then contention must favour requester 0.
        drive(1, 0, 0, 0, 0, 0, 0); step();
        wlog.delete(); clog.delete();
        i1 = 0;
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 0, 0, i1 < 4, 5'(r1_a[(i1 < 4) ? i1 : 3]), {4{32'(i1)}});
            step();
            if (acc1) i1++;
        end
        chk("r1_count", wlog.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("r1_a3_%0d", k), (k < wlog.size()) ? wlog[k] : -1, r1_a[k]);
        for (int k = 1; k < 4; k++)
            chk($sformatf("r1_gap_%0d", k), (k < clog.size()) ? clog[k] - clog[k-1] : -1, 1);
        drive(0, 1, 3, c_D1, 1, 4, c_D2); step();
        drive(0, 0, 0, 0, 0, 0, 0); step();
        chk("rr_first_we3", we3, 1);
        chk("rr_first_a3", a3, 3);
        step();
        chk("rr_second_a3", a3, 4);

        // Randomized traffic with occasional resets.
        drive(1, 0, 0, 0, 0, 0, 0); step();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 39) == 0,
                  1'($urandom), 5'($urandom), {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom), 5'($urandom), {$urandom, $urandom, $urandom, $urandom});
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
